// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port among NUM_REQ producers.
// A multi-beat packet locks the port to its producer for up to MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [ID_W-1:0]               grant_id,
    output logic                          locked
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state_r;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    owner_r;
    logic [CNT_W-1:0]   beat_cnt_r;

    logic [ID_W-1:0]    pick_s;
    logic [ID_W-1:0]    sel_s;
    logic               sel_valid_s;
    logic               sel_last_s;
    logic               grant_ok_s;
    logic               xfer_s;

    // Index addition modulo NUM_REQ; handles non-power-of-two producer counts.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input logic [ID_W-1:0] off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    // Round-robin pick: scan from the far end so the nearest valid index to rr_ptr wins.
    always_comb begin
        logic [ID_W-1:0] cand;
        pick_s = rr_ptr_r;
        cand   = rr_ptr_r;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand   = wrap_add(rr_ptr_r, ID_W'(k));
            pick_s = req_valid[cand] ? cand : pick_s;
        end
    end

    // Grant selection and handshake; reset and a full FIFO block every transfer.
    always_comb begin
        sel_s       = (state_r == LOCK) ? owner_r : pick_s;
        sel_valid_s = req_valid[sel_s];
        sel_last_s  = req_last[sel_s];
        grant_ok_s  = !rst && !fifo_full;
        xfer_s      = grant_ok_s && sel_valid_s;
        req_ready   = {NUM_REQ{1'b0}};
        if (grant_ok_s) begin
            req_ready[sel_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    assign fifo_wr_en   = xfer_s;
    assign fifo_data_in = req_data[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id     = owner_r;
    assign locked       = (state_r == LOCK);

    // Arbitration state: advances only on edges that carry a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= {ID_W{1'b0}};
            owner_r    <= {ID_W{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (xfer_s) begin
            case (state_r)
                IDLE: begin
                    owner_r <= pick_s;
                    if (sel_last_s || (MAX_BURST == 1)) begin
                        rr_ptr_r <= wrap_add(pick_s, ID_W'(1));
                    end else begin
                        state_r    <= LOCK;
                        beat_cnt_r <= CNT_W'(1);
                    end
                end
                LOCK: begin
                    beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    // A forced release leaves the packet open; the producer re-arbitrates.
                    if (sel_last_s || (beat_cnt_r + CNT_W'(1) == CNT_W'(MAX_BURST))) begin
                        state_r  <= IDLE;
                        rr_ptr_r <= wrap_add(owner_r, ID_W'(1));
                    end else begin
                        state_r <= LOCK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: table of single-beat arbitration vectors plus
// hand sequences for lock, full back-pressure, burst cap and mid-packet reset.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        locked;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [3:0] valid;
        logic       full;
        logic [3:0] ready;
        logic       wr;
        logic [7:0] data;
        logic [1:0] grant;
    } vec_t;

    vec_t vecs[16];

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .grant_id(grant_id), .locked(locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every FIFO write must match the next expected beat.
    task automatic mon();
        logic [7:0] e;
        if (fifo_wr_en !== 1'b0) begin
            chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h expected none", fifo_data_in);
            end else begin
                e = sb.pop_front();
                chk("fifo_data", {24'd0, fifo_data_in}, {24'd0, e});
            end
        end
    endtask

    task automatic at_negedge();
        @(negedge clk);
        mon();
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    initial begin
        int n1;
        logic p3_done;
        int n1_at_p3;
        logic [3:0] hs;

        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd0};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 8'hA2, 2'd1};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 8'hA3, 2'd2};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd3};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd0};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 8'hA2, 2'd1};
        vecs[7]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 8'hA3, 2'd2};
        vecs[8]  = '{4'b0000, 1'b0, 4'b0001, 1'b0, 8'hA0, 2'd3};
        vecs[9]  = '{4'b0110, 1'b1, 4'b0000, 1'b0, 8'hA1, 2'd3};
        vecs[10] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd3};
        vecs[11] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 8'hA3, 2'd1};
        vecs[12] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 8'hA3, 2'd3};
        vecs[13] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA2, 2'd3};
        vecs[14] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd2};
        vecs[15] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 8'hA1, 2'd0};

        // Reset with every producer requesting
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        fifo_full = 1'b0;
        at_negedge();
        at_negedge();
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        to_drive();
        rst = 1'b0;

        // Table: single-beat packets under varying request masks
        for (int i = 0; i < 16; i++) begin
            req_valid = vecs[i].valid;
            fifo_full = vecs[i].full;
            if (vecs[i].wr) sb.push_back(vecs[i].data);
            at_negedge();
            chk($sformatf("row%0d_ready", i), {28'd0, req_ready}, {28'd0, vecs[i].ready});
            chk($sformatf("row%0d_wr_en", i), {31'd0, fifo_wr_en}, {31'd0, vecs[i].wr});
            chk($sformatf("row%0d_data", i), {24'd0, fifo_data_in}, {24'd0, vecs[i].data});
            chk($sformatf("row%0d_grant", i), {30'd0, grant_id}, {30'd0, vecs[i].grant});
            chk($sformatf("row%0d_locked", i), {31'd0, locked}, 32'd0);
            to_drive();
        end

        // Lock: producer 2 sends 11,22,33 while producers 0 and 3 wait
        req_valid = 4'b1101;
        req_last  = 4'b1001;
        set_data(0, 8'h50);
        set_data(2, 8'h11);
        set_data(3, 8'h77);
        sb.push_back(8'h11);
        at_negedge();
        chk("lock0_ready", {28'd0, req_ready}, 32'b0100);
        chk("lock0_locked", {31'd0, locked}, 32'd0);
        to_drive();
        set_data(2, 8'h22);
        sb.push_back(8'h22);
        at_negedge();
        chk("lock1_ready", {28'd0, req_ready}, 32'b0100);
        chk("lock1_locked", {31'd0, locked}, 32'd1);
        chk("lock1_grant", {30'd0, grant_id}, 32'd2);
        to_drive();
        set_data(2, 8'h33);
        req_last = 4'b1101;
        sb.push_back(8'h33);
        at_negedge();
        chk("lock2_ready", {28'd0, req_ready}, 32'b0100);
        chk("lock2_locked", {31'd0, locked}, 32'd1);
        to_drive();
        req_valid = 4'b1001;
        sb.push_back(8'h77);
        at_negedge();
        chk("lock3_ready", {28'd0, req_ready}, 32'b1000);
        chk("lock3_locked", {31'd0, locked}, 32'd0);
        to_drive();
        req_valid = 4'b0001;
        sb.push_back(8'h50);
        at_negedge();
        chk("lock4_ready", {28'd0, req_ready}, 32'b0001);
        chk("lock4_grant", {30'd0, grant_id}, 32'd3);
        to_drive();
        req_valid = 4'b0000;

        // Burst cap: 12 beats from producer 1 split by producer 3's packet
        for (int b = 0; b < 8; b++) sb.push_back(8'h10 + 8'(b));
        sb.push_back(8'h3F);
        for (int b = 8; b < 12; b++) sb.push_back(8'h10 + 8'(b));
        n1 = 0;
        p3_done = 1'b0;
        n1_at_p3 = -1;
        set_data(3, 8'h3F);
        for (int c = 0; c < 40 && !(n1 == 12 && p3_done); c++) begin
            req_valid = {!p3_done, 1'b0, (n1 < 12), 1'b0};
            req_last  = {1'b1, 1'b0, (n1 == 11), 1'b0};
            set_data(1, 8'h10 + 8'(n1));
            at_negedge();
            hs = req_valid & req_ready;
            to_drive();
            if (hs[1]) n1++;
            if (hs[3]) begin
                p3_done = 1'b1;
                n1_at_p3 = n1;
            end
        end
        req_valid = 4'b0000;
        chk("burst_done", {30'd0, (n1 == 12), p3_done}, 32'b11);
        chk("burst_split", n1_at_p3, 32'd8);

        // Full: back-pressure after beat 1 of a 4-beat packet from producer 1
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        set_data(1, 8'hC1);
        sb.push_back(8'hC1);
        at_negedge();
        chk("full0_wr_en", {31'd0, fifo_wr_en}, 32'd1);
        to_drive();
        set_data(1, 8'hC2);
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            at_negedge();
            chk($sformatf("full%0d_wr_en", c + 1), {31'd0, fifo_wr_en}, 32'd0);
            chk($sformatf("full%0d_ready", c + 1), {28'd0, req_ready}, 32'd0);
            chk($sformatf("full%0d_locked", c + 1), {31'd0, locked}, 32'd1);
            chk($sformatf("full%0d_grant", c + 1), {30'd0, grant_id}, 32'd1);
            to_drive();
        end
        fifo_full = 1'b0;
        sb.push_back(8'hC2);
        at_negedge();
        to_drive();
        set_data(1, 8'hC3);
        sb.push_back(8'hC3);
        at_negedge();
        to_drive();
        set_data(1, 8'hC4);
        req_last = 4'b0010;
        sb.push_back(8'hC4);
        at_negedge();
        to_drive();
        req_valid = 4'b0000;
        at_negedge();
        chk("full_end_locked", {31'd0, locked}, 32'd0);
        chk("full_end_grant", {30'd0, grant_id}, 32'd1);
        to_drive();

        // Reset mid-packet after beat 2 of 5 from producer 0
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        set_data(0, 8'hE1);
        sb.push_back(8'hE1);
        at_negedge();
        to_drive();
        set_data(0, 8'hE2);
        sb.push_back(8'hE2);
        at_negedge();
        chk("mid_locked", {31'd0, locked}, 32'd1);
        to_drive();
        set_data(0, 8'hE3);
        rst = 1'b1;
        #1;
        chk("async_locked", {31'd0, locked}, 32'd0);
        chk("async_grant", {30'd0, grant_id}, 32'd0);
        chk("async_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("async_ready", {28'd0, req_ready}, 32'd0);
        at_negedge();
        to_drive();
        at_negedge();
        chk("rst_hold_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        to_drive();
        rst = 1'b0;
        req_valid = 4'b0000;
        at_negedge();
        chk("post_rst_locked", {31'd0, locked}, 32'd0);
        to_drive();
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        set_data(0, 8'h99);
        sb.push_back(8'h99);
        at_negedge();
        chk("post_rst_ready", {28'd0, req_ready}, 32'b0001);
        to_drive();
        req_valid = 4'b0000;
        at_negedge();

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
